obuf_port_arbiter: RTL and testbench

- Owns the single port of the output buffer SRAM (64 x 512b) and shares it between two requesters.
- Requester 1 is the controller's PE-array writeback stream; requester 2 is the host/testbench readout port.
- Replaces the static "controller-read wins" mux in the accelerator top level. Writeback goes through a small skid FIFO so the PE array is not stalled by host reads.
- A streak counter keeps the host from being starved, and an address-hazard check enforces read-after-write ordering.

---
 rtl/obuf_pkg.sv | 19 +
 rtl/obuf_port_arbiter_if.sv | 34 +++
 rtl/obuf_wb_fifo.sv | 63 ++++++
 rtl/obuf_port_arbiter.sv | 101 ++++++++++
 tb/tb_obuf_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/obuf_pkg.sv
// Shared defaults and encodings for the output-buffer SRAM port arbiter.
package obuf_pkg;

  localparam int unsigned DW_DEF            = 512;
  localparam int unsigned AW_DEF            = 6;
  localparam int unsigned WB_DEPTH_DEF      = 4;
  localparam int unsigned MAX_WB_STREAK_DEF = 4;

  // SRAM cen/wen are active-low strobes
  localparam logic SRAM_ACTIVE   = 1'b0;
  localparam logic SRAM_INACTIVE = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WRITE,
    ARB_READ
  } arb_op_e;

endpackage

// File: rtl/obuf_port_arbiter_if.sv
// Writeback stream, host readout and SRAM port signals of the output buffer.
interface obuf_port_arbiter_if #(
  parameter int unsigned DW = 512,
  parameter int unsigned AW = 6
);
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_ready;
  logic          wb_empty;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_rvalid;
  logic [DW-1:0] rd_rdata;
  logic          sram_cen;
  logic          sram_wen;
  logic          sram_retn;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  modport slave (
    input  wb_valid, wb_addr, wb_data, rd_req, rd_addr, sram_q,
    output wb_ready, wb_empty, rd_gnt, rd_rvalid, rd_rdata,
           sram_cen, sram_wen, sram_retn, sram_addr, sram_d
  );

  modport master (
    output wb_valid, wb_addr, wb_data, rd_req, rd_addr, sram_q,
    input  wb_ready, wb_empty, rd_gnt, rd_rvalid, rd_rdata,
           sram_cen, sram_wen, sram_retn, sram_addr, sram_d
  );
endinterface

// File: rtl/obuf_wb_fifo.sv
// Writeback skid FIFO; o_hit flags any occupied entry whose address matches i_cmp_addr.
module obuf_wb_fifo #(
  parameter int unsigned DW    = 512,
  parameter int unsigned AW    = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  input  logic [AW-1:0] i_cmp_addr,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_empty_nxt,
  output logic [AW-1:0] o_head_addr,
  output logic [DW-1:0] o_head_data,
  output logic          o_hit
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0]   r_wptr, r_rptr;
  logic [PW:0]   w_wptr_nxt, w_rptr_nxt, w_count;
  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic          w_push, w_pop;

  assign w_count     = r_wptr - r_rptr;
  assign o_empty     = (r_wptr == r_rptr);
  assign o_full      = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_push      = i_push && !o_full;
  assign w_pop       = i_pop && !o_empty;
  assign w_wptr_nxt  = w_push ? r_wptr + 1'b1 : r_wptr;
  assign w_rptr_nxt  = w_pop  ? r_rptr + 1'b1 : r_rptr;
  assign o_empty_nxt = (w_wptr_nxt == w_rptr_nxt);
  assign o_head_addr = r_addr[r_rptr[PW-1:0]];
  assign o_head_data = r_data[r_rptr[PW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_addr[r_wptr[PW-1:0]] <= i_addr;
        r_data[r_wptr[PW-1:0]] <= i_data;
      end
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
    end
  end

  // An entry is occupied when its distance from the read pointer is below the count
  always_comb begin
    o_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (({1'b0, PW'(PW'(i) - r_rptr[PW-1:0])} < w_count) && (r_addr[i] == i_cmp_addr))
        o_hit = 1'b1;
    end
  end

endmodule

// File: rtl/obuf_port_arbiter.sv
// Shares the single output-buffer SRAM port between PE writeback (via skid FIFO) and host reads.
module obuf_port_arbiter
  import obuf_pkg::*;
#(
  parameter int unsigned DW            = DW_DEF,
  parameter int unsigned AW            = AW_DEF,
  parameter int unsigned WB_DEPTH      = WB_DEPTH_DEF,
  parameter int unsigned MAX_WB_STREAK = MAX_WB_STREAK_DEF
) (
  input logic                CLK,
  input logic                RESET,
  obuf_port_arbiter_if.slave bus
);
  localparam int unsigned    SW         = $clog2(MAX_WB_STREAK + WB_DEPTH + 1);
  localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_WB_STREAK);
  localparam logic [SW-1:0]  STREAK_SAT = SW'(MAX_WB_STREAK + WB_DEPTH);

  arb_op_e       w_op;
  logic          w_full, w_empty, w_empty_nxt, w_hit, w_hz, w_pop;
  logic [AW-1:0] w_head_addr;
  logic [DW-1:0] w_head_data;
  logic [SW-1:0] r_streak, w_streak_nxt;
  logic          r_rvalid, r_wb_empty;

  obuf_wb_fifo #(.DW(DW), .AW(AW), .DEPTH(WB_DEPTH)) u_wb_fifo (
    .i_clk       (CLK),
    .i_rst       (RESET),
    .i_push      (bus.wb_valid),
    .i_addr      (bus.wb_addr),
    .i_data      (bus.wb_data),
    .i_pop       (w_pop),
    .i_cmp_addr  (bus.rd_addr),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_empty_nxt (w_empty_nxt),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_hit       (w_hit)
  );

  assign w_hz          = bus.rd_req && w_hit;
  assign bus.wb_ready  = !w_full;
  assign bus.wb_empty  = r_wb_empty;
  assign bus.rd_rvalid = r_rvalid;
  assign bus.rd_rdata  = bus.sram_q;
  assign bus.sram_retn = 1'b1;

  // A pending hazard always lets the write win, so the streak may run past its limit
  always_comb begin
    w_op = ARB_IDLE;
    if (!RESET) begin
      if (!w_empty && (!bus.rd_req || w_hz || (r_streak < STREAK_MAX)))
        w_op = ARB_WRITE;
      else if (bus.rd_req && !w_hz)
        w_op = ARB_READ;
    end
  end

  always_comb begin
    bus.sram_cen  = SRAM_INACTIVE;
    bus.sram_wen  = SRAM_INACTIVE;
    bus.sram_addr = '0;
    bus.sram_d    = '0;
    bus.rd_gnt    = 1'b0;
    w_pop         = 1'b0;
    w_streak_nxt  = r_streak;
    case (w_op)
      ARB_WRITE: begin
        bus.sram_cen  = SRAM_ACTIVE;
        bus.sram_wen  = SRAM_ACTIVE;
        bus.sram_addr = w_head_addr;
        bus.sram_d    = w_head_data;
        w_pop         = 1'b1;
        if (!bus.rd_req)
          w_streak_nxt = '0;
        else if (r_streak != STREAK_SAT)
          w_streak_nxt = r_streak + 1'b1;
      end
      ARB_READ: begin
        bus.sram_cen  = SRAM_ACTIVE;
        bus.sram_addr = bus.rd_addr;
        bus.rd_gnt    = 1'b1;
        w_streak_nxt  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_streak   <= '0;
      r_rvalid   <= 1'b0;
      r_wb_empty <= 1'b1;
    end else begin
      r_streak   <= w_streak_nxt;
      r_rvalid   <= (w_op == ARB_READ);
      r_wb_empty <= w_empty_nxt;
    end
  end

endmodule

// File: tb/tb_obuf_port_arbiter.sv
// Directed bench for obuf_port_arbiter with a behavioural 64 x 512b single-port SRAM.
module tb_obuf_port_arbiter;
  localparam int unsigned DW = 512;
  localparam int unsigned AW = 6;

  logic clk = 1'b0;
  logic RESET;
  logic preload;
  int   checks = 0;
  int   errors = 0;
  int   accesses = 0;

  logic [DW-1:0] mem [64];
  logic [DW-1:0] q;

  always #5 clk = ~clk;

  obuf_port_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  obuf_port_arbiter #(.DW(DW), .AW(AW), .WB_DEPTH(4), .MAX_WB_STREAK(4)) dut (
    .CLK   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] pat(input logic [31:0] w);
    return {16{w}};
  endfunction

  function automatic logic [DW-1:0] pre(input int i);
    return pat(32'hC0DE_0000 + i);
  endfunction

  always @(posedge clk) begin
    if (!bus.sram_cen) accesses++;
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= pre(i);
    end else if (!bus.sram_cen) begin
      if (!bus.sram_wen) mem[bus.sram_addr] <= bus.sram_d;
      else               q <= mem[bus.sram_addr];
    end
  end
  assign bus.sram_q = q;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [AW:0] obs, input logic [AW:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (!bus.wb_empty && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chkb(tag, bus.wb_empty, 1'b1);
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int n = 0;
    @(negedge clk);
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    #1;
    while (!bus.rd_gnt && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chkb({tag, "_gnt"}, bus.rd_gnt, 1'b1);
    @(negedge clk);
    bus.rd_req = 1'b0;
    #1;
    chkb({tag, "_rvalid"}, bus.rd_rvalid, 1'b1);
    chk({tag, "_rdata"}, bus.rd_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW:0] oplog [$];
    logic [AW:0] exp2 [7];
    logic [AW:0] exp5 [11];
    int k, n, run, max_run, wr_cnt, wi;
    bit saw_full, order_ok;

    exp2 = '{7'd84, 7'd40, 7'd41, 7'd42, 7'd43, 7'd84, 7'd44};
    exp5 = '{7'd85, 7'd10, 7'd11, 7'd12, 7'd13, 7'd85, 7'd14, 7'd15, 7'd16, 7'd17, 7'd85};

    // Reset held with both requesters active
    RESET        = 1'b1;
    preload      = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 6'd1;
    bus.wb_data  = pat(32'h1111_1111);
    bus.rd_req   = 1'b1;
    bus.rd_addr  = 6'd2;
    repeat (2) begin
      @(negedge clk); #1;
      chkb("rst_wb_ready", bus.wb_ready, 1'b1);
      chkb("rst_wb_empty", bus.wb_empty, 1'b1);
      chkb("rst_sram_cen", bus.sram_cen, 1'b1);
      chkb("rst_rvalid", bus.rd_rvalid, 1'b0);
      chkb("rst_rd_gnt", bus.rd_gnt, 1'b0);
      chk("rst_sram_d", bus.sram_d, '0);
      chka("rst_sram_addr", {1'b0, bus.sram_addr}, 7'd0);
    end
    @(negedge clk);
    RESET        = 1'b0;
    preload      = 1'b0;
    bus.wb_valid = 1'b0;
    bus.rd_req   = 1'b0;
    #1;
    chki("rst_no_access", accesses, 0);
    chkb("rst_retn", bus.sram_retn, 1'b1);

    // Write then read
    @(negedge clk);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 6'd5;
    bus.wb_data  = pat(32'hA5A5_A5A5);
    #1;
    chkb("wr_ready", bus.wb_ready, 1'b1);
    chkb("wr_idle_cen", bus.sram_cen, 1'b1);
    @(negedge clk);
    bus.wb_valid = 1'b0;
    #1;
    chkb("wr_cen", bus.sram_cen, 1'b0);
    chkb("wr_wen", bus.sram_wen, 1'b0);
    chka("wr_addr", {1'b0, bus.sram_addr}, 7'd5);
    chk("wr_d", bus.sram_d, pat(32'hA5A5_A5A5));
    chkb("wr_not_empty", bus.wb_empty, 1'b0);
    wait_empty("wr_empty");
    @(negedge clk);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 6'd5;
    #1;
    chkb("rd_gnt", bus.rd_gnt, 1'b1);
    chkb("rd_cen", bus.sram_cen, 1'b0);
    chkb("rd_wen", bus.sram_wen, 1'b1);
    chka("rd_addr", {1'b0, bus.sram_addr}, 7'd5);
    @(negedge clk);
    bus.rd_req = 1'b0;
    #1;
    chkb("rd_gnt_drop", bus.rd_gnt, 1'b0);
    chkb("rd_rvalid", bus.rd_rvalid, 1'b1);
    chk("rd_rdata", bus.rd_rdata, pat(32'hA5A5_A5A5));

    // Backpressure: 24 beats to 40..63 with a host read of 20 held throughout
    k = 0; n = 0; run = 0; max_run = 0; saw_full = 0;
    while (k < 24 && n < 200) begin
      @(negedge clk);
      bus.rd_req   = 1'b1;
      bus.rd_addr  = 6'd20;
      bus.wb_valid = 1'b1;
      bus.wb_addr  = AW'(40 + k);
      bus.wb_data  = pat(32'h0000_0200 + k);
      #1;
      if (!bus.wb_ready) saw_full = 1;
      if (!bus.sram_cen) oplog.push_back({bus.sram_wen, bus.sram_addr});
      if (!bus.sram_cen && !bus.sram_wen && bus.rd_req) begin
        run++;
        if (run > max_run) max_run = run;
      end else if (!bus.sram_cen) run = 0;
      if (bus.wb_ready) k++;
      n++;
    end
    chki("bp_all_accepted", k, 24);
    n = 0;
    @(negedge clk);
    bus.wb_valid = 1'b0;
    bus.rd_req   = 1'b0;
    #1;
    while (n < 100) begin
      if (!bus.sram_cen) oplog.push_back({bus.sram_wen, bus.sram_addr});
      if (bus.wb_empty) break;
      @(negedge clk); #1;
      n++;
    end
    chkb("bp_drained", bus.wb_empty, 1'b1);
    for (int i = 0; i < 7; i++) chka($sformatf("bp_op%0d", i), oplog[i], exp2[i]);
    wr_cnt = 0; wi = 0; order_ok = 1;
    foreach (oplog[i]) begin
      if (!oplog[i][AW]) begin
        if (oplog[i][AW-1:0] != AW'(40 + wi)) order_ok = 0;
        wi++;
        wr_cnt++;
      end
    end
    chki("bp_write_count", wr_cnt, 24);
    chkb("bp_write_order", order_ok, 1'b1);
    chki("bp_max_streak", max_run, 4);
    chkb("bp_saw_full", saw_full, 1'b1);
    for (int i = 0; i < 24; i++) chk($sformatf("bp_mem%0d", 40 + i), mem[40 + i], pat(32'h0000_0200 + i));
    do_read("bp_readback63", 6'd63, pat(32'h0000_0217));

    // RAW hazard: streak at limit, yet the write to the requested address must go first
    @(negedge clk);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 6'd30;
    bus.wb_data  = pat(32'h0000_0030);
    #1;
    chkb("hz_h0_cen", bus.sram_cen, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.rd_req   = 1'b1;
      bus.rd_addr  = 6'd9;
      bus.wb_addr  = (i == 4) ? 6'd9 : AW'(30 + i);
      bus.wb_data  = (i == 4) ? pat(32'h9999_9999) : pat(32'h0000_0030 + i);
      #1;
      chkb($sformatf("hz_h%0d_gnt", i), bus.rd_gnt, 1'b0);
      chka($sformatf("hz_h%0d_waddr", i), {bus.sram_wen, bus.sram_addr}, 7'(29 + i));
    end
    @(negedge clk);
    bus.wb_valid = 1'b0;
    #1;
    chkb("hz_h5_gnt", bus.rd_gnt, 1'b0);
    chka("hz_h5_op", {bus.sram_wen, bus.sram_addr}, 7'd9);
    chk("hz_h5_d", bus.sram_d, pat(32'h9999_9999));
    @(negedge clk); #1;
    chkb("hz_h6_gnt", bus.rd_gnt, 1'b1);
    chka("hz_h6_addr", {1'b0, bus.sram_addr}, 7'd9);
    @(negedge clk);
    bus.rd_req = 1'b0;
    #1;
    chkb("hz_rvalid", bus.rd_rvalid, 1'b1);
    chk("hz_rdata", bus.rd_rdata, pat(32'h9999_9999));

    // Back-to-back reads of 0..3
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      bus.rd_req  = (c < 4);
      bus.rd_addr = AW'(c % 4);
      #1;
      chkb($sformatf("b2b_gnt%0d", c), bus.rd_gnt, (c < 4));
      if (c > 0) begin
        chkb($sformatf("b2b_rvalid%0d", c), bus.rd_rvalid, 1'b1);
        chk($sformatf("b2b_rdata%0d", c), bus.rd_rdata, pre(c - 1));
      end
    end

    // Mid-operation reset with three entries held and a read in flight
    oplog.delete();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      bus.rd_req   = 1'b1;
      bus.rd_addr  = 6'd21;
      bus.wb_valid = 1'b1;
      bus.wb_addr  = AW'(10 + c);
      bus.wb_data  = pat(32'h0000_0500 + c);
      #1;
      if (!bus.sram_cen) oplog.push_back({bus.sram_wen, bus.sram_addr});
      if (!bus.wb_ready) chkb($sformatf("mr_ready%0d", c), bus.wb_ready, 1'b1);
    end
    chki("mr_op_count", oplog.size(), 11);
    for (int i = 0; i < 11 && i < oplog.size(); i++) chka($sformatf("mr_op%0d", i), oplog[i], exp5[i]);
    @(negedge clk);
    RESET        = 1'b1;
    bus.wb_valid = 1'b0;
    bus.rd_req   = 1'b0;
    #1;
    chkb("mr_inflight_rvalid", bus.rd_rvalid, 1'b1);
    chk("mr_inflight_rdata", bus.rd_rdata, pre(21));
    chkb("mr_rst_cen", bus.sram_cen, 1'b1);
    chkb("mr_pre_empty", bus.wb_empty, 1'b0);
    @(negedge clk);
    RESET = 1'b0;
    #1;
    chkb("mr_rvalid_cleared", bus.rd_rvalid, 1'b0);
    chkb("mr_wb_empty", bus.wb_empty, 1'b1);
    chkb("mr_idle_cen", bus.sram_cen, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chkb("mr_still_idle", bus.sram_cen, 1'b1);
    for (int i = 0; i < 11; i++)
      chk($sformatf("mr_mem%0d", 10 + i), mem[10 + i], (i < 8) ? pat(32'h0000_0500 + i) : pre(10 + i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
